// File: rtl/sub_pipe.sv
// Pipelined two's-complement subtractor: a + ~b + 1 through a Kogge-Stone carry
// prefix split over three register stages, with valid/ready on both sides.
module sub_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LVL  = $clog2(WIDTH);
    localparam int LVL1 = (LVL + 1) / 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic ld1, ld2, ld3, accept;

    logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic [WIDTH-1:0] p1_q, p1_d, gg1_q, gg1_d, gp1_q, gp1_d;
    logic [WIDTH-1:0] p2_q, p2_d, gg2_q, gg2_d;
    logic             sa1_q, sa1_d, sb1_q, sb1_d, sa2_q, sa2_d, sb2_q, sb2_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [WIDTH-1:0] nb, g_s1, p_s1, g_s2, p_s2, sum;

    // A stage loads when the one after it is empty or draining this cycle.
    always_comb begin
        ld3      = out_ready || !v3_q;
        ld2      = !v2_q || ld3;
        ld1      = !v1_q || ld2;
        in_ready = ld1 && !flush;
        accept   = in_valid && in_ready;
        v1_d     = flush ? 1'b0 : (ld1 ? accept : v1_q);
        v2_d     = flush ? 1'b0 : (ld2 ? v1_q : v2_q);
        v3_d     = flush ? 1'b0 : (ld3 ? v2_q : v3_q);
    end

    // Stage 1: bitwise g/p with the +1 carry-in folded into bit 0, first prefix levels.
    always_comb begin
        nb      = ~b;
        g_s1    = a & nb;
        g_s1[0] = a[0] | nb[0];
        p_s1    = a ^ nb;
        for (int k = 0; k < LVL1; k++) begin
            g_s1 = g_s1 | (p_s1 & (g_s1 << (1 << k)));
            p_s1 = p_s1 & ((p_s1 << (1 << k)) | ((ONE << (1 << k)) - ONE));
        end
        tag1_d = tag1_q;
        p1_d   = p1_q;
        gg1_d  = gg1_q;
        gp1_d  = gp1_q;
        sa1_d  = sa1_q;
        sb1_d  = sb1_q;
        if (accept) begin
            tag1_d = in_tag;
            p1_d   = a ^ nb;
            gg1_d  = g_s1;
            gp1_d  = p_s1;
            sa1_d  = a[WIDTH-1];
            sb1_d  = b[WIDTH-1];
        end
    end

    // Stage 2: remaining prefix levels; only the group generate is needed afterwards.
    always_comb begin
        g_s2 = gg1_q;
        p_s2 = gp1_q;
        for (int k = LVL1; k < LVL; k++) begin
            g_s2 = g_s2 | (p_s2 & (g_s2 << (1 << k)));
            p_s2 = p_s2 & ((p_s2 << (1 << k)) | ((ONE << (1 << k)) - ONE));
        end
        tag2_d = tag2_q;
        p2_d   = p2_q;
        gg2_d  = gg2_q;
        sa2_d  = sa2_q;
        sb2_d  = sb2_q;
        if (ld2 && v1_q) begin
            tag2_d = tag1_q;
            p2_d   = p1_q;
            gg2_d  = g_s2;
            sa2_d  = sa1_q;
            sb2_d  = sb1_q;
        end
    end

    // Stage 3: carry into bit i is the group generate of bits below it.
    always_comb begin
        sum      = p2_q ^ {gg2_q[WIDTH-2:0], 1'b1};
        tag3_d   = tag3_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (ld3 && v2_q) begin
            tag3_d   = tag2_q;
            diff_d   = sum;
            borrow_d = !gg2_q[WIDTH-1];
            ovf_d    = (sa2_q ^ sb2_q) & (sa2_q ^ sum[WIDTH-1]);
            zero_d   = (sum == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            tag3_q   <= '0;
            p1_q     <= '0;
            gg1_q    <= '0;
            gp1_q    <= '0;
            p2_q     <= '0;
            gg2_q    <= '0;
            sa1_q    <= 1'b0;
            sb1_q    <= 1'b0;
            sa2_q    <= 1'b0;
            sb2_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            tag3_q   <= tag3_d;
            p1_q     <= p1_d;
            gg1_q    <= gg1_d;
            gp1_q    <= gp1_d;
            p2_q     <= p2_d;
            gg2_q    <= gg2_d;
            sa1_q    <= sa1_d;
            sb1_q    <= sb1_d;
            sa2_q    <= sa2_d;
            sb2_q    <= sb2_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_sub_pipe.sv
// Bench for sub_pipe: directed vectors with literal expectations, plus a queue
// model checked every cycle (results, order, latency, in_ready, stall stability).
module tb_sub_pipe;
    localparam int WIDTH = 64;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready, out_valid, borrow, ovf, zero;
    logic [WIDTH-1:0] diff;
    logic [TAG_W-1:0] out_tag;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             br;
        logic             ov;
        logic             z;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic exp_ir, exp_ov, prev_stall = 1'b0;
    res_t cur, prev_out;
    exp_t e;

    sub_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: plain unsigned and sign-extended arithmetic.
    function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic [TAG_W-1:0] tv);
        res_t r;
        logic signed [WIDTH:0] full;
        full  = $signed({av[WIDTH-1], av}) - $signed({bv[WIDTH-1], bv});
        r.d   = av - bv;
        r.br  = (av < bv);
        r.ov  = full[WIDTH] ^ full[WIDTH-1];
        r.z   = (r.d == '0);
        r.tag = tv;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [TAG_W-1:0] tv);
        int tries;
        tries    = 0;
        a        = av;
        b        = bv;
        in_tag   = tv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) checkOutput("accept timeout", 80'd0, 80'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic expectResult(input string name, input res_t expv, input int lat);
        int waited;
        waited    = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 20);
        checkOutput(name, {diff, borrow, ovf, zero, out_tag}, expv);
        if (lat > 0) checkOutput({name, " latency"}, waited, lat);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rand_word(input logic [WIDTH-1:0] other);
        logic [WIDTH-1:0] w;
        case ($urandom_range(0, 5))
            0:       w = '0;
            1:       w = '1;
            2:       w = {1'b1, {(WIDTH-1){1'b0}}};
            3:       w = other;
            default: w = {$urandom, $urandom};
        endcase
        return w;
    endfunction

    // Per-cycle compare against the queue model, then advance the model past the coming edge.
    always @(negedge clk) begin
        cyc++;
        cur = {diff, borrow, ovf, zero, out_tag};
        if (!rst_n) begin
            checkOutput("reset out_valid", out_valid, 1'b0);
            checkOutput("reset outputs", cur, '0);
            q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_ir = !flush && (q.size() < 3 || out_ready);
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 3);
            checkOutput("in_ready", in_ready, exp_ir);
            checkOutput("out_valid", out_valid, exp_ov);
            if (exp_ov) checkOutput("result", cur, q[0].r);
            if (prev_stall) checkOutput("stall stable", cur, prev_out);
            prev_stall = exp_ov && !out_ready && !flush;
            prev_out   = cur;
            if (exp_ov && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && exp_ir) begin
                e.r   = model(a, b, in_tag);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    initial begin
        int nxt, got, lastc;

        // Pin the model to hand-computed values.
        checkOutput("model 5-3", model(64'd5, 64'd3, 6'd1), res_t'{64'd2, 1'b0, 1'b0, 1'b0, 6'd1});
        checkOutput("model 0-1", model(64'd0, 64'd1, 6'd2), res_t'{'1, 1'b1, 1'b0, 1'b0, 6'd2});
        checkOutput("model min-1", model(64'h8000_0000_0000_0000, 64'd1, 6'd3),
                    res_t'{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 6'd3});
        checkOutput("model 0-ones", model(64'd0, '1, 6'd5), res_t'{64'd1, 1'b1, 1'b0, 1'b0, 6'd5});

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset diff", diff, 64'd0);
        checkOutput("reset out_valid lit", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        applyStimulus(64'd5, 64'd3, 6'd1);
        in_valid = 1'b0;
        expectResult("5-3", res_t'{64'd2, 1'b0, 1'b0, 1'b0, 6'd1}, 3);
        applyStimulus(64'd0, 64'd1, 6'd2);
        in_valid = 1'b0;
        expectResult("0-1", res_t'{'1, 1'b1, 1'b0, 1'b0, 6'd2}, 3);
        applyStimulus(64'h8000_0000_0000_0000, 64'd1, 6'd3);
        in_valid = 1'b0;
        expectResult("min-1", res_t'{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 6'd3}, 3);
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 6'd4);
        in_valid = 1'b0;
        expectResult("equal", res_t'{64'd0, 1'b0, 1'b0, 1'b1, 6'd4}, 3);
        applyStimulus(64'd0, '1, 6'd5);
        in_valid = 1'b0;
        expectResult("ripple", res_t'{64'd1, 1'b1, 1'b0, 1'b0, 6'd5}, 3);

        // Backpressure: five offers against a stalled consumer, then release.
        out_ready = 1'b0;
        nxt   = 1;
        got   = 0;
        lastc = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) out_ready = 1'b1;
            in_valid = (nxt <= 5);
            a        = 64'd100 + 64'(nxt);
            b        = 64'(nxt);
            in_tag   = TAG_W'(nxt);
            @(negedge clk);
            if (c == 7) begin
                checkOutput("bp accepted", nxt - 1, 3);
                checkOutput("bp in_ready low", in_ready, 1'b0);
            end
            if (out_valid && out_ready) begin
                checkOutput("bp order", out_tag, got + 1);
                if (got > 0) checkOutput("bp no bubble", c - lastc, 1);
                got++;
                lastc = c;
            end
            if (in_valid && in_ready) nxt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("bp delivered", got, 5);

        // Flush with a full pipe and a simultaneous offer.
        out_ready = 1'b0;
        applyStimulus(64'd10, 64'd1, 6'd10);
        applyStimulus(64'd11, 64'd1, 6'd11);
        applyStimulus(64'd12, 64'd1, 6'd12);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 6'd13;
        @(negedge clk);
        checkOutput("flush in_ready", in_ready, 1'b0);
        checkOutput("flush out_valid before", out_valid, 1'b1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush out_valid after", out_valid, 1'b0);
        out_ready = 1'b1;
        applyStimulus(64'd7, 64'd9, 6'd14);
        in_valid = 1'b0;
        expectResult("after flush", res_t'{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 6'd14}, 3);

        // Asynchronous reset mid-cycle with a full pipe.
        out_ready = 1'b0;
        applyStimulus(64'd20, 64'd2, 6'd20);
        applyStimulus(64'd21, 64'd2, 6'd21);
        applyStimulus(64'd22, 64'd2, 6'd22);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", out_valid, 1'b0);
        checkOutput("async reset data", {diff, borrow, ovf, zero, out_tag}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after async reset", in_ready, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(64'd30, 64'd30, 6'd30);
        in_valid = 1'b0;
        expectResult("after reset", res_t'{64'd0, 1'b0, 1'b0, 1'b1, 6'd30}, 3);

        // Random regression; the per-cycle compare does the checking.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 299) == 0);
            a         = rand_word('0);
            b         = rand_word(a);
            in_tag    = TAG_W'($urandom);
            @(posedge clk);
            #1;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("drain empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
